// File: rtl/axis_fir_stereo_sequencer.sv
// rtl/axis_fir_stereo_sequencer.sv - shares one mono FIR between the L and R channels of an AXIS stereo stream
module axis_fir_stereo_sequencer #(
  parameter int SAMPLE_W = 24,
  parameter int FIR_W    = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic             axis_clk,
  input  logic             axis_reset,
  input  logic [31:0]      s_axis_data,
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  input  logic             s_axis_last,
  output logic [FIR_W-1:0] fir_m_data,
  output logic             fir_m_valid,
  input  logic             fir_m_ready,
  input  logic [FIR_W-1:0] fir_s_data,
  input  logic             fir_s_valid,
  output logic             fir_s_ready,
  output logic [31:0]      m_axis_data,
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
  output logic             m_axis_last,
  input  logic             bypass,
  output logic             timeout_flag,
  output logic [7:0]       frame_err_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    RX_L, RX_R, FIR_L_SEND, FIR_L_WAIT, FIR_R_SEND, FIR_R_WAIT, TX_L, TX_R
  } state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] l_smp;
  logic [SAMPLE_W-1:0] r_smp;
  logic [CW-1:0]       cnt;

  logic rx_xfer;
  logic fir_sent;
  logic fir_got;
  logic fir_expired;
  logic tx_xfer;
  logic unused_hi;

  assign rx_xfer     = s_axis_valid && s_axis_ready;
  assign fir_sent    = fir_m_valid && fir_m_ready;
  assign fir_got     = fir_s_valid && fir_s_ready;
  assign fir_expired = (cnt == CW'(TIMEOUT - 1));
  assign tx_xfer     = m_axis_valid && m_axis_ready;
  // The upper bits of a received word carry no audio.
  assign unused_hi   = ^s_axis_data[31:SAMPLE_W];

  function automatic logic [FIR_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
    return {{(FIR_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  function automatic logic [31:0] zext(input logic [SAMPLE_W-1:0] s);
    return {{(32 - SAMPLE_W){1'b0}}, s};
  endfunction

  // Clamp a signed FIR result into the audio sample range: the result fits only
  // when every bit from the sample sign bit upward agrees with the FIR sign bit.
  function automatic logic [SAMPLE_W-1:0] saturate(input logic [FIR_W-1:0] v);
    logic [FIR_W-SAMPLE_W:0] top;
    top = v[FIR_W-1:SAMPLE_W-1];
    if (!v[FIR_W-1] && (|top)) begin
      return {1'b0, {(SAMPLE_W - 1){1'b1}}};
    end else if (v[FIR_W-1] && !(&top)) begin
      return {1'b1, {(SAMPLE_W - 1){1'b0}}};
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

  // Packet sequencer: every handshake output is a register updated on the state transition.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state         <= RX_L;
      s_axis_ready  <= 1'b0;
      fir_m_valid   <= 1'b0;
      fir_s_ready   <= 1'b0;
      m_axis_valid  <= 1'b0;
      m_axis_last   <= 1'b0;
      fir_m_data    <= '0;
      m_axis_data   <= '0;
      l_smp         <= '0;
      r_smp         <= '0;
      cnt           <= '0;
      timeout_flag  <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      // Results are always accepted so late FIR outputs drain instead of stalling the FIR.
      fir_s_ready <= 1'b1;
      case (state)
        RX_L: begin
          s_axis_ready <= 1'b1;
          if (rx_xfer) begin
            if (s_axis_last) begin
              if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
            end else begin
              l_smp <= s_axis_data[SAMPLE_W-1:0];
              state <= RX_R;
            end
          end
        end
        RX_R: begin
          s_axis_ready <= 1'b1;
          if (rx_xfer) begin
            if (s_axis_last) begin
              r_smp        <= s_axis_data[SAMPLE_W-1:0];
              s_axis_ready <= 1'b0;
              if (bypass) begin
                state        <= TX_L;
                m_axis_valid <= 1'b1;
                m_axis_last  <= 1'b0;
                m_axis_data  <= zext(l_smp);
              end else begin
                state       <= FIR_L_SEND;
                fir_m_valid <= 1'b1;
                fir_m_data  <= sext(l_smp);
              end
            end else begin
              // A second L without an R: resync on the newest L.
              l_smp <= s_axis_data[SAMPLE_W-1:0];
              if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
            end
          end
        end
        FIR_L_SEND: begin
          if (fir_sent) begin
            fir_m_valid <= 1'b0;
            cnt         <= '0;
            state       <= FIR_L_WAIT;
          end
        end
        FIR_L_WAIT: begin
          if (fir_got || fir_expired) begin
            l_smp       <= fir_got ? saturate(fir_s_data) : '0;
            if (!fir_got) timeout_flag <= 1'b1;
            state       <= FIR_R_SEND;
            fir_m_valid <= 1'b1;
            fir_m_data  <= sext(r_smp);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIR_R_SEND: begin
          if (fir_sent) begin
            fir_m_valid <= 1'b0;
            cnt         <= '0;
            state       <= FIR_R_WAIT;
          end
        end
        FIR_R_WAIT: begin
          if (fir_got || fir_expired) begin
            r_smp        <= fir_got ? saturate(fir_s_data) : '0;
            if (!fir_got) timeout_flag <= 1'b1;
            state        <= TX_L;
            m_axis_valid <= 1'b1;
            m_axis_last  <= 1'b0;
            m_axis_data  <= zext(l_smp);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_L: begin
          if (tx_xfer) begin
            state       <= TX_R;
            m_axis_last <= 1'b1;
            m_axis_data <= zext(r_smp);
          end
        end
        TX_R: begin
          if (tx_xfer) begin
            state        <= RX_L;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= '0;
            s_axis_ready <= 1'b1;
          end
        end
        default: state <= RX_L;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fir_stereo_sequencer.sv
// tb/tb_axis_fir_stereo_sequencer.sv - self-checking bench for axis_fir_stereo_sequencer
module tb_axis_fir_stereo_sequencer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        axis_reset;
  logic [31:0] s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic        s_axis_last;
  logic [31:0] fir_m_data;
  logic        fir_m_valid;
  logic        fir_m_ready;
  logic [31:0] fir_s_data;
  logic        fir_s_valid;
  logic        fir_s_ready;
  logic [31:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        m_axis_last;
  logic        bypass;
  logic        timeout_flag;
  logic [7:0]  frame_err_cnt;

  axis_fir_stereo_sequencer #(.SAMPLE_W(24), .FIR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .axis_clk(clk), .axis_reset(axis_reset),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_last(s_axis_last),
    .fir_m_data(fir_m_data), .fir_m_valid(fir_m_valid), .fir_m_ready(fir_m_ready),
    .fir_s_data(fir_s_data), .fir_s_valid(fir_s_valid), .fir_s_ready(fir_s_ready),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last), .bypass(bypass), .timeout_flag(timeout_flag),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIR model: doubles its input (or returns programmed values) after a latency.
  typedef struct { int due; logic [31:0] val; } resp_t;
  resp_t       rq[$];
  bit          fir_ovr = 0;
  logic [31:0] ovr_l = '0, ovr_r = '0;
  int          lat_l = 3, lat_r = 3;
  bit          lat_rand = 0;
  bit          fir_par = 0;
  int          fir_xfers = 0;
  int          xfer_cyc[$];
  bit          mrdy_rand = 0;
  logic [32:0] outq[$];

  always @(negedge clk) begin
    if (!axis_reset && fir_m_valid && fir_m_ready) begin
      resp_t e;
      int lat;
      lat   = lat_rand ? int'($urandom_range(1, 5)) : (fir_par ? lat_r : lat_l);
      e.due = cyc + lat;
      e.val = fir_ovr ? (fir_par ? ovr_r : ovr_l) : (fir_m_data * 32'd2);
      rq.push_back(e);
      xfer_cyc.push_back(cyc);
      fir_xfers = fir_xfers + 1;
      fir_par   = ~fir_par;
    end
  end

  // Present at most one due FIR result per cycle.
  always @(posedge clk) begin
    #1;
    fir_s_valid = 1'b0;
    for (int i = 0; i < rq.size(); i++) begin
      if (rq[i].due <= cyc) begin
        fir_s_valid = 1'b1;
        fir_s_data  = rq[i].val;
        rq.delete(i);
        break;
      end
    end
  end

  // Record every output word that is transferred.
  always @(negedge clk) begin
    if (!axis_reset && m_axis_valid && m_axis_ready) outq.push_back({m_axis_last, m_axis_data});
  end

  always @(posedge clk) begin
    #1;
    if (mrdy_rand) m_axis_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    rq.delete();
    step();
    step();
    rq.delete();
    fir_par = 0;
    axis_reset = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic byp);
    bit ok;
    s_axis_data  = d;
    s_axis_last  = last;
    bypass       = byp;
    s_axis_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (s_axis_ready) begin
        ok = 1;
        break;
      end
    end
    step();
    s_axis_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 3000 && outq.size() < n; i++) @(negedge clk);
    chk("out_word_count", 64'(outq.size()), 64'(n));
    step();
  endtask

  function automatic logic [32:0] pop_word();
    if (outq.size() > 0) return outq.pop_front();
    return 33'h1_FFFF_FFFF;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic longint sext24(input logic [31:0] w);
    longint x;
    x = longint'(w[23:0]);
    if (w[23]) x = x - 64'sd16777216;
    return x;
  endfunction

  function automatic logic [31:0] sat24(input longint v);
    if (v > 64'sd8388607) return 32'h007F_FFFF;
    if (v < -64'sd8388608) return 32'h0080_0000;
    return 32'(v) & 32'h00FF_FFFF;
  endfunction

  function automatic logic [31:0] exp_sample(input logic [31:0] in, input logic byp);
    return byp ? (in & 32'h00FF_FFFF) : sat24(2 * sext24(in));
  endfunction

  typedef struct {
    logic [31:0] l, r;
    logic        byp, use_ovr;
    logic [31:0] ovl, ovrv;
    logic [31:0] el, er;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

  initial begin
    int n, bad, dt, err;
    logic [32:0] w0, w1;
    logic [34:0] snap;
    logic [31:0] d, pl;
    logic        last, byp, pend;
    logic [32:0] expq[$];

    vecs[0] = '{32'h0000_0123, 32'h00FF_FF00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0246, 32'h00FF_FE00};
    vecs[1] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'h0100_0000, 32'hFF00_0000, 32'h007F_FFFF, 32'h0080_0000};
    vecs[2] = '{32'h00AB_CDEF, 32'h0012_3456, 1'b1, 1'b0, 32'h0, 32'h0, 32'h00AB_CDEF, 32'h0012_3456};
    vecs[3] = '{32'h003F_FFFF, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h007F_FFFE, 32'h007F_FFFF};
    vecs[4] = '{32'h00C0_0000, 32'h00BF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0080_0000, 32'h0080_0000};
    vecs[5] = '{32'hFF12_3456, 32'h12FE_DCBA, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0012_3456, 32'h00FE_DCBA};

    axis_reset = 1'b1; s_axis_data = '0; s_axis_valid = 1'b0; s_axis_last = 1'b0;
    fir_m_ready = 1'b1; fir_s_data = '0; fir_s_valid = 1'b0; m_axis_ready = 1'b1; bypass = 1'b0;

    // Reset values.
    step(); step();
    @(negedge clk);
    chk("rst_handshakes", 64'({s_axis_ready, fir_m_valid, fir_s_ready, m_axis_valid, m_axis_last}), 64'd0);
    chk("rst_fir_m_data", 64'(fir_m_data), 64'd0);
    chk("rst_m_axis_data", 64'(m_axis_data), 64'd0);
    chk("rst_flags", 64'({timeout_flag, frame_err_cnt}), 64'd0);
    step();
    axis_reset = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_ready", 64'({s_axis_ready, fir_s_ready}), 64'd3);
    step();

    // Table-driven packets through FIR and bypass.
    lat_l = 3; lat_r = 3;
    for (int i = 0; i < 6; i++) begin
      n = fir_xfers;
      outq.delete();
      fir_ovr = vecs[i].use_ovr; ovr_l = vecs[i].ovl; ovr_r = vecs[i].ovrv;
      send_word(vecs[i].l, 1'b0, vecs[i].byp);
      send_word(vecs[i].r, 1'b1, vecs[i].byp);
      wait_words(2);
      w0 = pop_word(); w1 = pop_word();
      chk($sformatf("vec%0d_l", i), 64'(w0), 64'({1'b0, vecs[i].el}));
      chk($sformatf("vec%0d_r", i), 64'(w1), 64'({1'b1, vecs[i].er}));
      chk($sformatf("vec%0d_fir_xfers", i), 64'(fir_xfers - n), vecs[i].byp ? 64'd0 : 64'd2);
    end
    fir_ovr = 0;
    chk("table_flags", 64'({timeout_flag, frame_err_cnt}), 64'd0);

    // Latency with a zero-wait FIR.
    lat_l = 1; lat_r = 1;
    outq.delete();
    send_word(32'h0080_0001, 1'b0, 1'b0);
    send_word(32'h0000_0005, 1'b1, 1'b0);
    @(negedge clk);
    n = 1;
    chk("lat_fir_valid", 64'(fir_m_valid), 64'd1);
    chk("lat_fir_sext", 64'(fir_m_data), 64'hFF80_0001);
    while (!m_axis_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("lat_tx_cycle_in_5_to_8", 64'(n >= 5 && n <= 8), 64'd1);
    wait_words(2);
    chk("lat_l", 64'(pop_word()), 64'({1'b0, 32'h0080_0000}));
    chk("lat_r", 64'(pop_word()), 64'({1'b1, 32'h0000_000A}));

    // Bypass latency: TX_L valid in the cycle right after R capture.
    n = fir_xfers;
    send_word(32'h00AB_CDEF, 1'b0, 1'b1);
    send_word(32'h0012_3456, 1'b1, 1'b1);
    @(negedge clk);
    chk("byp_tx_next_cycle", 64'({m_axis_valid, m_axis_data}), 64'({1'b1, 32'h00AB_CDEF}));
    wait_words(2);
    void'(pop_word()); void'(pop_word());
    chk("byp_no_fir", 64'(fir_xfers - n), 64'd0);

    // Framing errors: orphan R, then L, L, R.
    do_reset();
    outq.delete();
    send_word(32'h0000_0111, 1'b1, 1'b1);
    send_word(32'h0000_0222, 1'b0, 1'b1);
    send_word(32'h0000_0333, 1'b0, 1'b1);
    send_word(32'h0000_0444, 1'b1, 1'b1);
    wait_words(2);
    chk("frm_l", 64'(pop_word()), 64'({1'b0, 32'h0000_0333}));
    chk("frm_r", 64'(pop_word()), 64'({1'b1, 32'h0000_0444}));
    chk("frm_err_cnt", 64'(frame_err_cnt), 64'd2);

    // Back-pressure, then reset during TX_R.
    do_reset();
    outq.delete();
    m_axis_ready = 1'b0;
    send_word(32'h0011_1111, 1'b0, 1'b1);
    send_word(32'h0022_2222, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !m_axis_valid; i++) @(negedge clk);
    snap = {m_axis_valid, m_axis_last, s_axis_ready, m_axis_data};
    chk("bp_first", 64'(snap), 64'({3'b100, 32'h0011_1111}));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({m_axis_valid, m_axis_last, s_axis_ready, m_axis_data} !== snap) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    step();
    m_axis_ready = 1'b1;
    step();
    m_axis_ready = 1'b0;
    @(negedge clk);
    chk("bp_tx_r", 64'({m_axis_valid, m_axis_last, m_axis_data}), 64'({2'b11, 32'h0022_2222}));
    step();
    axis_reset = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_handshakes", 64'({s_axis_ready, fir_m_valid, fir_s_ready, m_axis_valid, m_axis_last}), 64'd0);
    chk("mid_rst_data", 64'({fir_m_data, m_axis_data}), 64'd0);
    step();
    axis_reset = 1'b0;
    rq.delete();
    fir_par = 0;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("mid_rst_no_partial", 64'(outq.size()), 64'd1);
    outq.delete();
    lat_l = 2; lat_r = 2;
    send_word(32'h0000_0050, 1'b0, 1'b0);
    send_word(32'h0000_0060, 1'b1, 1'b0);
    wait_words(2);
    chk("post_rst_l", 64'(pop_word()), 64'({1'b0, 32'h0000_00A0}));
    chk("post_rst_r", 64'(pop_word()), 64'({1'b1, 32'h0000_00C0}));

    // FIR timeout on L; the late L result lands during TX and is dropped.
    do_reset();
    outq.delete();
    xfer_cyc.delete();
    m_axis_ready = 1'b0;
    lat_l = 300; lat_r = 3;
    send_word(32'h0000_0100, 1'b0, 1'b0);
    send_word(32'h0000_0200, 1'b1, 1'b0);
    for (int i = 0; i < 400 && xfer_cyc.size() < 2; i++) @(negedge clk);
    chk("to_r_sent", 64'(xfer_cyc.size()), 64'd2);
    dt = (xfer_cyc.size() >= 2) ? (xfer_cyc[1] - xfer_cyc[0]) : 0;
    chk("to_interval", 64'(dt >= TIMEOUT && dt <= TIMEOUT + 2), 64'd1);
    chk("to_flag_set", 64'(timeout_flag), 64'd1);
    for (int i = 0; i < 50 && !m_axis_valid; i++) @(negedge clk);
    for (int i = 0; i < 100 && rq.size() > 0; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("to_late_dropped", 64'({rq.size() == 0, m_axis_valid, m_axis_last, m_axis_data}), 64'({3'b110, 32'h0}));
    step();
    m_axis_ready = 1'b1;
    wait_words(2);
    chk("to_l_zero", 64'(pop_word()), 64'({1'b0, 32'h0}));
    chk("to_r_ok", 64'(pop_word()), 64'({1'b1, 32'h0000_0400}));
    chk("to_flag_sticky", 64'(timeout_flag), 64'd1);

    // Randomized stream against the packet-assembly model.
    do_reset();
    outq.delete();
    lat_rand = 1;
    mrdy_rand = 1;
    err = 0; pend = 0; pl = '0;
    for (int i = 0; i < 60; i++) begin
      d    = $urandom;
      last = (i % 2 == 1);
      if ($urandom_range(0, 7) == 0) last = ~last;
      byp  = ($urandom_range(0, 3) == 0);
      send_word(d, last, byp);
      if (last) begin
        if (pend) begin
          expq.push_back({1'b0, exp_sample(pl, byp)});
          expq.push_back({1'b1, exp_sample(d, byp)});
          pend = 0;
        end else begin
          err++;
        end
      end else begin
        if (pend) err++;
        pend = 1;
        pl   = d;
      end
    end
    for (int i = 0; i < 3000 && outq.size() < expq.size(); i++) @(negedge clk);
    mrdy_rand = 0;
    step();
    m_axis_ready = 1'b1;
    lat_rand = 0;
    chk("rnd_count", 64'(outq.size()), 64'(expq.size()));
    for (int k = 0; k < expq.size(); k++) begin
      chk($sformatf("rnd_word%0d", k), 64'(pop_word()), 64'(expq[k]));
    end
    chk("rnd_err_cnt", 64'(frame_err_cnt), 64'(err));
    chk("rnd_no_timeout", 64'(timeout_flag), 64'd0);

    // frame_err_cnt saturates at 255.
    do_reset();
    outq.delete();
    for (int i = 0; i < 260; i++) send_word(32'h0000_0001, 1'b1, 1'b0);
    chk("err_saturate", 64'(frame_err_cnt), 64'd255);
    chk("err_no_output", 64'(outq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
